// File: rtl/fc8_mem_arbiter_pkg.sv
// Shared definitions for the fc8 memory arbiter: requester indices, FSM states,
// the protected page-select address and a saturating counter helper.
package fc8_arb_pkg;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;
    localparam int REQ_VID = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    localparam logic [15:0] PAGE_SELECT_ADDR = 16'h00FE;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fc8_mem_arbiter_if.sv
// Requester-side bundle of the fc8 arbiter: three request channels plus the
// shared grant / read-return signals.
interface fc8_mem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_wdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [7:0]        rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output vid_req, vid_addr,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  vid_req, vid_addr,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/fc8_mem_arbiter_pick.sv
// Combinational winner selector: video has priority until its burst limit is
// hit while others wait; CPU and DMA alternate when both request.
module fc8_arb_pick
    import fc8_arb_pkg::*;
(
    input  logic [2:0] reqs,
    input  logic       rr_last_dma,
    input  logic       burst_limit_hit,
    output logic [2:0] win
);

    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        win = '0;
        if (reqs[REQ_VID] && (!burst_limit_hit || !(reqs[REQ_CPU] || reqs[REQ_DMA]))) begin
            win[REQ_VID] = 1'b1;
        end else if (reqs[REQ_CPU] && reqs[REQ_DMA]) begin
            if (rr_last_dma) win[REQ_CPU] = 1'b1;
            else             win[REQ_DMA] = 1'b1;
        end else if (reqs[REQ_CPU]) begin
            win[REQ_CPU] = 1'b1;
        end else if (reqs[REQ_DMA]) begin
            win[REQ_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/fc8_mem_arbiter.sv
// fc8 memory port arbiter (video / CPU / DMA) with page-select write guard.
// Optional grant/wait statistics counters under `define FC8_ARB_STATS_EN.
module fc8_mem_arbiter
    import fc8_arb_pkg::*;
#(
    parameter int VID_BURST_MAX = 8,
    parameter int ADDR_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fc8_mem_arbiter_if.slave  req_if,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              prot_err
`ifdef FC8_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_gnt_cpu,
    output logic [15:0]       stat_gnt_dma,
    output logic [15:0]       stat_gnt_vid,
    output logic [15:0]       stat_cpu_wait
`endif
);

    localparam logic [7:0] BURST_MAX = 8'(VID_BURST_MAX);

    state_t            state;
    logic [2:0]        owner;
    logic              we_q;
    logic              rr_last_dma;
    logic [7:0]        burst_cnt;
    logic [2:0]        reqs;
    logic [2:0]        win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;
    logic              drop;

    assign reqs = {req_if.vid_req, req_if.dma_req, req_if.cpu_req};

    fc8_arb_pick u_pick (
        .reqs            (reqs),
        .rr_last_dma     (rr_last_dma),
        .burst_limit_hit (burst_cnt >= BURST_MAX),
        .win             (win)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (win[REQ_CPU]) begin
            sel_we    = req_if.cpu_we;
            sel_addr  = req_if.cpu_addr;
            sel_wdata = req_if.cpu_wdata;
        end else if (win[REQ_DMA]) begin
            sel_we    = req_if.dma_we;
            sel_addr  = req_if.dma_addr;
            sel_wdata = req_if.dma_wdata;
        end else if (win[REQ_VID]) begin
            sel_addr  = req_if.vid_addr;
        end
    end

    // Only the CPU may write the page-select register; other writers are squashed.
    assign drop = sel_we && !win[REQ_CPU] && (sel_addr == ADDR_W'(PAGE_SELECT_ADDR));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= '0;
            we_q          <= 1'b0;
            rr_last_dma   <= 1'b1;
            burst_cnt     <= '0;
            req_if.gnt    <= '0;
            req_if.rvalid <= '0;
            req_if.rdata  <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            busy          <= 1'b0;
            prot_err      <= 1'b0;
        end else begin
            req_if.gnt    <= '0;
            req_if.rvalid <= '0;
            mem_we        <= 1'b0;
            prot_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (!req_if.vid_req) burst_cnt <= '0;
                    if (|reqs) begin
                        owner      <= win;
                        we_q       <= sel_we;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_we     <= sel_we && !drop;
                        prot_err   <= drop;
                        req_if.gnt <= win;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                        if (win[REQ_VID]) begin
                            if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
                        end else begin
                            burst_cnt   <= '0;
                            rr_last_dma <= win[REQ_DMA];
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    req_if.rdata  <= mem_rdata;
                    req_if.rvalid <= owner;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FC8_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_gnt_cpu  <= '0;
            stat_gnt_dma  <= '0;
            stat_gnt_vid  <= '0;
            stat_cpu_wait <= '0;
        end else if (stat_clr) begin
            stat_gnt_cpu  <= '0;
            stat_gnt_dma  <= '0;
            stat_gnt_vid  <= '0;
            stat_cpu_wait <= '0;
        end else begin
            if (req_if.gnt[REQ_CPU]) stat_gnt_cpu <= sat_inc16(stat_gnt_cpu);
            if (req_if.gnt[REQ_DMA]) stat_gnt_dma <= sat_inc16(stat_gnt_dma);
            if (req_if.gnt[REQ_VID]) stat_gnt_vid <= sat_inc16(stat_gnt_vid);
            if (req_if.cpu_req && !req_if.gnt[REQ_CPU])
                stat_cpu_wait <= sat_inc16(stat_cpu_wait);
        end
    end
`endif

endmodule

// File: tb/tb_fc8_mem_arbiter.sv
// Scoreboard bench for fc8_mem_arbiter: stimulus queues expected grants and
// read returns; a negedge monitor pops and compares them as the DUT presents them.
module tb_fc8_mem_arbiter;
    import fc8_arb_pkg::*;

    typedef struct {
        logic [2:0]  gnt;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        mem_we;
        logic        prot;
        int          cyc;
    } gnt_exp_t;

    typedef struct {
        logic [2:0] rvalid;
        logic [7:0] rdata;
        int         cyc;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic        prot_err;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    gnt_exp_t    gq[$];
    rd_exp_t     rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc8_mem_arbiter_if #(.ADDR_W(16)) bus();

`ifdef FC8_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_gnt_cpu, stat_gnt_dma, stat_gnt_vid, stat_cpu_wait;
`endif

    fc8_mem_arbiter #(.VID_BURST_MAX(8), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (bus.slave),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .prot_err  (prot_err)
`ifdef FC8_ARB_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_gnt_cpu  (stat_gnt_cpu),
        .stat_gnt_dma  (stat_gnt_dma),
        .stat_gnt_vid  (stat_gnt_vid),
        .stat_cpu_wait (stat_cpu_wait)
`endif
    );

    // Controller model: one-cycle registered read of an address-derived pattern.
    always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h5A;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        gnt_exp_t g;
        rd_exp_t  r;
        if (rst_n) begin
            if (bus.gnt !== 3'b000) begin
                if (gq.size() == 0) begin
                    check("gnt_unexpected", 32'(bus.gnt), 32'h0);
                end else begin
                    g = gq.pop_front();
                    check("gnt", 32'(bus.gnt), 32'(g.gnt));
                    check("mem_addr", 32'(mem_addr), 32'(g.addr));
                    check("mem_wdata", 32'(mem_wdata), 32'(g.wdata));
                    check("mem_we", 32'(mem_we), 32'(g.mem_we));
                    check("prot_err", 32'(prot_err), 32'(g.prot));
                    check("gnt_cycle", cyc, g.cyc);
                end
            end else if (prot_err !== 1'b0) begin
                check("prot_err_stray", 32'(prot_err), 32'h0);
            end
            if (bus.rvalid !== 3'b000) begin
                if (rq.size() == 0) begin
                    check("rvalid_unexpected", 32'(bus.rvalid), 32'h0);
                end else begin
                    r = rq.pop_front();
                    check("rvalid", 32'(bus.rvalid), 32'(r.rvalid));
                    check("rdata", 32'(bus.rdata), 32'(r.rdata));
                    check("rvalid_cycle", cyc, r.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g(input logic [2:0] g, input logic [15:0] a, input logic [7:0] wd,
                          input logic we, input logic pe, input int c);
        gnt_exp_t e;
        e.gnt = g; e.addr = a; e.wdata = wd; e.mem_we = we; e.prot = pe; e.cyc = c;
        gq.push_back(e);
    endtask

    task automatic push_r(input logic [2:0] v, input logic [7:0] d, input int c);
        rd_exp_t e;
        e.rvalid = v; e.rdata = d; e.cyc = c;
        rq.push_back(e);
    endtask

    task automatic wait_gnt(input int idx, output bit ok);
        logic [2:0] want;
        want = '0;
        want[idx] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.gnt[idx] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("gnt_timeout", 32'(bus.gnt), 32'(want));
    endtask

    task automatic wait_any_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.gnt !== 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("any_gnt_timeout", 32'(bus.gnt), 32'h7);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gq.size() == 0 && rq.size() == 0 && busy === 1'b0) return;
        end
        check("drain_timeout", 32'(gq.size() + rq.size()) + 32'(busy), 32'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'h0);
        check({tag, "_rdata"}, 32'(bus.rdata), 32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_prot_err"}, 32'(prot_err), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got hang expected finish");
        $fatal(1);
    end

    initial begin : stim
        int t;
        bit ok;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.vid_req = 0; bus.vid_addr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // CPU and DMA writes held: alternate CPU first, 2 cycles apart.
        t = cyc;
        push_g(3'b001, 16'h4000, 8'hA1, 1'b1, 1'b0, t + 1);
        push_g(3'b010, 16'h5000, 8'hB2, 1'b1, 1'b0, t + 3);
        push_g(3'b001, 16'h4000, 8'hA1, 1'b1, 1'b0, t + 5);
        push_g(3'b010, 16'h5000, 8'hB2, 1'b1, 1'b0, t + 7);
        bus.cpu_we = 1; bus.cpu_addr = 16'h4000; bus.cpu_wdata = 8'hA1;
        bus.dma_we = 1; bus.dma_addr = 16'h5000; bus.dma_wdata = 8'hB2;
        bus.cpu_req = 1; bus.dma_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_any_gnt(ok);
            if (!ok) break;
        end
        bus.cpu_req = 0; bus.dma_req = 0;
        wait_idle();

        // CPU read of $1234: gnt at T+1, rvalid at T+3 with $34^$12^$5A = $7C.
        tick();
        t = cyc;
        push_g(3'b001, 16'h1234, 8'h00, 1'b0, 1'b0, t + 1);
        push_r(3'b001, 8'h7C, t + 3);
        bus.cpu_we = 0; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'h00;
        bus.cpu_req = 1;
        wait_gnt(REQ_CPU, ok);
        bus.cpu_req = 0;
        wait_idle();

        // Video + CPU reads held: 8 video, 1 CPU, 8 video, 3 cycles apart.
        tick();
        t = cyc;
        for (int k = 0; k < 17; k++) begin
            if (k == 8) begin
                push_g(3'b001, 16'h2000, 8'h00, 1'b0, 1'b0, t + 1 + 3 * k);
                push_r(3'b001, 8'h7A, t + 3 + 3 * k);
            end else begin
                push_g(3'b100, 16'h8000, 8'h00, 1'b0, 1'b0, t + 1 + 3 * k);
                push_r(3'b100, 8'hDA, t + 3 + 3 * k);
            end
        end
        bus.vid_addr = 16'h8000; bus.cpu_addr = 16'h2000; bus.cpu_we = 0;
        bus.vid_req = 1; bus.cpu_req = 1;
        for (int k = 0; k < 17; k++) begin
            wait_any_gnt(ok);
            if (!ok) break;
        end
        bus.vid_req = 0; bus.cpu_req = 0;
        wait_idle();

        // DMA write to page-select is dropped; CPU write of the same goes through.
        tick();
        t = cyc;
        push_g(3'b010, 16'h00FE, 8'h05, 1'b0, 1'b1, t + 1);
        bus.dma_we = 1; bus.dma_addr = 16'h00FE; bus.dma_wdata = 8'h05;
        bus.dma_req = 1;
        wait_gnt(REQ_DMA, ok);
        bus.dma_req = 0;
        wait_idle();
        tick();
        t = cyc;
        push_g(3'b001, 16'h00FE, 8'h05, 1'b1, 1'b0, t + 1);
        bus.cpu_we = 1; bus.cpu_addr = 16'h00FE; bus.cpu_wdata = 8'h05;
        bus.cpu_req = 1;
        wait_gnt(REQ_CPU, ok);
        bus.cpu_req = 0;
        wait_idle();

        // Reset during ISSUE of a video read: no rvalid, everything back to zero.
        tick();
        t = cyc;
        push_g(3'b100, 16'h9000, 8'h00, 1'b0, 1'b0, t + 1);
        bus.vid_addr = 16'h9000;
        bus.vid_req = 1;
        wait_gnt(REQ_VID, ok);
        #2;
        rst_n = 1'b0;
        bus.vid_req = 0;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_rvalid_after_reset", 32'(bus.rvalid), 32'h0);
        check("idle_after_reset", 32'(busy), 32'h0);

        // First request after reset: CPU read of $0042 -> $42^$00^$5A = $18.
        tick();
        t = cyc;
        push_g(3'b001, 16'h0042, 8'h00, 1'b0, 1'b0, t + 1);
        push_r(3'b001, 8'h18, t + 3);
        bus.cpu_we = 0; bus.cpu_addr = 16'h0042; bus.cpu_wdata = 8'h00;
        bus.cpu_req = 1;
        wait_gnt(REQ_CPU, ok);
        bus.cpu_req = 0;
        wait_idle();

        // DMA request withdrawn while the CPU read is in DONE: never granted.
        tick();
        t = cyc;
        push_g(3'b001, 16'h0300, 8'h00, 1'b0, 1'b0, t + 1);
        push_r(3'b001, 8'h59, t + 3);
        bus.cpu_addr = 16'h0300;
        bus.cpu_req = 1;
        wait_gnt(REQ_CPU, ok);
        bus.cpu_req = 0;
        bus.dma_we = 0; bus.dma_addr = 16'h0777;
        bus.dma_req = 1;
        @(negedge clk);
        check("busy_in_done", 32'(busy), 32'h1);
        bus.dma_req = 0;
        @(negedge clk);
        check("busy_after_read", 32'(busy), 32'h0);
        @(negedge clk);
        check("busy_no_req", 32'(busy), 32'h0);
        check("no_dma_gnt", 32'(bus.gnt), 32'h0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
